ctrl_sequencer: RTL

- Parametrised hardwired control sequencer for the single-bus 32-bit datapath: Moore FSM producing the per-step control word.
- Successor features:
  - memory handshake with wait states and timeout
  - parametrised register-file size and link register
  - conditional branch short-cut
  - illegal-opcode trap
  - Stop/Resume at instruction boundary
- Sits between IR/CON flip-flop and datapath; drives memory strobes and register-select logic.

---
 rtl/ctrl_pkg.sv | 90 +++++++++
 rtl/ctrl_decode.sv | 40 ++++
 rtl/ctrl_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the hardwired control sequencer.
//   - CW_* : bit positions inside the 27-bit control word
//   - OP_* : 5-bit opcode values (IR[IR_W-1 -: OPC_W])
//   - cls_e : instruction class, decoded once in T3 and then held
//   - state_e : sequencer step codes (also exported on the State debug port)
package ctrl_pkg;

  localparam int CW_W = 27;

  localparam int CW_HIIN      = 0;
  localparam int CW_LOIN      = 1;
  localparam int CW_PCIN      = 2;
  localparam int CW_MDRIN     = 3;
  localparam int CW_ZIN       = 4;
  localparam int CW_YIN       = 5;
  localparam int CW_MARIN     = 6;
  localparam int CW_IRIN      = 7;
  localparam int CW_CONIN     = 8;
  localparam int CW_OUTPORTIN = 9;
  localparam int CW_HIOUT     = 10;
  localparam int CW_LOOUT     = 11;
  localparam int CW_ZHIOUT    = 12;
  localparam int CW_ZLOOUT    = 13;
  localparam int CW_PCOUT     = 14;
  localparam int CW_MDROUT    = 15;
  localparam int CW_INPORTOUT = 16;
  localparam int CW_COUT      = 17;
  localparam int CW_GRA       = 18;
  localparam int CW_GRB       = 19;
  localparam int CW_GRC       = 20;
  localparam int CW_RIN       = 21;
  localparam int CW_ROUT      = 22;
  localparam int CW_BAOUT     = 23;
  localparam int CW_READ      = 24;
  localparam int CW_WRITE     = 25;
  localparam int CW_INCPC     = 26;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [4:0] {
    CLS_ALU, CLS_ALUI, CLS_MULDIV, CLS_UNARY, CLS_LD, CLS_LDI, CLS_ST,
    CLS_BR, CLS_JR, CLS_JAL, CLS_MFHI, CLS_MFLO, CLS_IN, CLS_OUT,
    CLS_NOP, CLS_HLT, CLS_ILL
  } cls_e;

  typedef enum logic [4:0] {
    ST_INIT = 5'd0,
    ST_F0   = 5'd1,
    ST_F1   = 5'd2,
    ST_F2   = 5'd3,
    ST_T3   = 5'd4,
    ST_T4   = 5'd5,
    ST_T5   = 5'd6,
    ST_T6   = 5'd7,
    ST_T7   = 5'd8,
    ST_HALT = 5'd9
  } state_e;

  // One-hot control-word term, so step encodings read as a list of signals.
  function automatic logic [CW_W-1:0] cw_bit(input int unsigned idx);
    return {{(CW_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> instruction class.
//   opcode : IR opcode field
//   cls    : decoded class; any unlisted opcode decodes to CLS_ILL
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output cls_e             cls
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path through the block can leave it unassigned and infer a latch.
    cls = CLS_ILL;
    case (opcode)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_SHR), OPC_W'(OP_SHL),
      OPC_W'(OP_ROR), OPC_W'(OP_ROL), OPC_W'(OP_AND), OPC_W'(OP_OR):
        cls = CLS_ALU;
      OPC_W'(OP_ADDI), OPC_W'(OP_ANDI), OPC_W'(OP_ORI): cls = CLS_ALUI;
      OPC_W'(OP_MUL), OPC_W'(OP_DIV):                   cls = CLS_MULDIV;
      OPC_W'(OP_NEG), OPC_W'(OP_NOT):                   cls = CLS_UNARY;
      OPC_W'(OP_LD):                                    cls = CLS_LD;
      OPC_W'(OP_LDI):                                   cls = CLS_LDI;
      OPC_W'(OP_ST):                                    cls = CLS_ST;
      OPC_W'(OP_BR):                                    cls = CLS_BR;
      OPC_W'(OP_JR):                                    cls = CLS_JR;
      OPC_W'(OP_JAL):                                   cls = CLS_JAL;
      OPC_W'(OP_MFHI):                                  cls = CLS_MFHI;
      OPC_W'(OP_MFLO):                                  cls = CLS_MFLO;
      OPC_W'(OP_IN):                                    cls = CLS_IN;
      OPC_W'(OP_OUT):                                   cls = CLS_OUT;
      OPC_W'(OP_NOP):                                   cls = CLS_NOP;
      OPC_W'(OP_HALT):                                  cls = CLS_HLT;
      default:                                          cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: Moore-style hardwired control sequencer for the single-bus
// 32-bit datapath. Fetch (F0-F2), class-dependent execute steps (T3-T7),
// memory wait states with optional timeout, illegal-opcode trap and
// Stop/Resume at instruction boundaries.
//   Clock, Reset : clock; asynchronous active-high reset (forces INIT)
//   Stop         : level, halt at the next instruction boundary
//   Resume       : pulse, leave HALT (Stop has priority)
//   MemReady     : memory completes the pending Read/Write this cycle
//   IR, CON      : instruction register and branch-condition flip-flop
//   CW           : 27-bit control word (bit order in ctrl_pkg CW_*)
//   RegClr       : per-register load-enable override (reset clear / link)
//   Run          : low only in HALT
//   BusErr/IllOp : sticky error flags, cleared only by Reset
//   State        : current step code, debug
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int IR_W     = 32,
  parameter int OPC_W    = 5,
  parameter int NUM_REGS = 16,
  parameter int LINK_REG = 15,
  parameter int WAIT_MAX = 255
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Stop,
  input  logic                Resume,
  input  logic                MemReady,
  input  logic [IR_W-1:0]     IR,
  input  logic                CON,
  output logic [26:0]         CW,
  output logic [NUM_REGS-1:0] RegClr,
  output logic                Run,
  output logic                BusErr,
  output logic                IllOp,
  output logic [4:0]          State
);

  localparam int CNT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  // Wait-cycle index at which a still-missing MemReady becomes a bus error.
  localparam int WAIT_LAST = (WAIT_MAX == 0) ? 0 : WAIT_MAX - 1;

  state_e              state_q, state_d;
  cls_e                cls_q, dec_cls, cls_cur;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                bus_err_q, ill_op_q;
  logic                set_bus_err, set_ill, last_step, in_wait;
  logic [CW_W-1:0]     cw;
  logic [NUM_REGS-1:0] reg_clr;

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic unused_ir;
  assign unused_ir = ^IR[IR_W-OPC_W-1:0];

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode (IR[IR_W-1 -: OPC_W]),
    .cls    (dec_cls)
  );

  // IR is only trusted in T3 (it was loaded at the end of F2); afterwards the
  // class comes from the register captured at the T3 edge.
  assign cls_cur = (state_q == ST_T3) ? dec_cls : cls_q;

  always_comb begin
    state_d     = state_q;
    cw          = '0;
    reg_clr     = '0;
    last_step   = 1'b0;
    in_wait     = 1'b0;
    set_bus_err = 1'b0;
    set_ill     = 1'b0;

    case (state_q)
      ST_INIT: begin
        reg_clr = '1;
        cw      = cw_bit(CW_PCIN);
        state_d = ST_F0;
      end
      ST_F0: begin
        cw      = cw_bit(CW_PCOUT) | cw_bit(CW_MARIN);
        state_d = ST_F1;
      end
      ST_F1: begin
        cw      = cw_bit(CW_READ) | cw_bit(CW_MDRIN);
        in_wait = 1'b1;
        if (MemReady) state_d = ST_F2;
      end
      ST_F2: begin
        cw      = cw_bit(CW_MDROUT) | cw_bit(CW_IRIN) | cw_bit(CW_INCPC) | cw_bit(CW_PCIN);
        state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        case (cls_cur)
          CLS_ALU, CLS_ALUI, CLS_MULDIV:
            cw = cw_bit(CW_GRB) | cw_bit(CW_ROUT) | cw_bit(CW_YIN);
          CLS_UNARY:
            cw = cw_bit(CW_GRB) | cw_bit(CW_ROUT) | cw_bit(CW_ZIN);
          CLS_LD, CLS_LDI, CLS_ST:
            cw = cw_bit(CW_GRB) | cw_bit(CW_BAOUT) | cw_bit(CW_YIN);
          CLS_BR:
            cw = cw_bit(CW_GRA) | cw_bit(CW_ROUT) | cw_bit(CW_CONIN);
          CLS_JR: begin
            cw        = cw_bit(CW_GRA) | cw_bit(CW_ROUT) | cw_bit(CW_PCIN);
            last_step = 1'b1;
          end
          CLS_JAL: begin
            cw                = cw_bit(CW_PCOUT);
            reg_clr[LINK_REG] = 1'b1;
          end
          CLS_MFHI: begin
            cw        = cw_bit(CW_HIOUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN);
            last_step = 1'b1;
          end
          CLS_MFLO: begin
            cw        = cw_bit(CW_LOOUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN);
            last_step = 1'b1;
          end
          CLS_IN: begin
            cw        = cw_bit(CW_INPORTOUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN);
            last_step = 1'b1;
          end
          CLS_OUT: begin
            cw        = cw_bit(CW_GRA) | cw_bit(CW_ROUT) | cw_bit(CW_OUTPORTIN);
            last_step = 1'b1;
          end
          CLS_NOP: last_step = 1'b1;
          CLS_HLT: state_d = ST_HALT;
          default: begin
            set_ill = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        case (cls_cur)
          CLS_ALU, CLS_MULDIV:
            cw = cw_bit(CW_GRC) | cw_bit(CW_ROUT) | cw_bit(CW_ZIN);
          CLS_ALUI, CLS_LD, CLS_LDI, CLS_ST:
            cw = cw_bit(CW_COUT) | cw_bit(CW_ZIN);
          CLS_UNARY: begin
            cw        = cw_bit(CW_ZLOOUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN);
            last_step = 1'b1;
          end
          CLS_BR: begin
            // Condition false: the branch finishes here without touching PC.
            if (CON) cw = cw_bit(CW_PCOUT) | cw_bit(CW_YIN);
            else     last_step = 1'b1;
          end
          CLS_JAL: begin
            cw        = cw_bit(CW_GRA) | cw_bit(CW_ROUT) | cw_bit(CW_PCIN);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T5: begin
        state_d = ST_T6;
        case (cls_cur)
          CLS_ALU, CLS_ALUI, CLS_LDI: begin
            cw        = cw_bit(CW_ZLOOUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN);
            last_step = 1'b1;
          end
          CLS_MULDIV: cw = cw_bit(CW_ZLOOUT) | cw_bit(CW_LOIN);
          CLS_LD, CLS_ST: cw = cw_bit(CW_ZLOOUT) | cw_bit(CW_MARIN);
          CLS_BR: cw = cw_bit(CW_COUT) | cw_bit(CW_ZIN);
          default: last_step = 1'b1;
        endcase
      end
      ST_T6: begin
        state_d = ST_T7;
        case (cls_cur)
          CLS_MULDIV: begin
            cw        = cw_bit(CW_ZHIOUT) | cw_bit(CW_HIIN);
            last_step = 1'b1;
          end
          CLS_LD: begin
            cw      = cw_bit(CW_READ) | cw_bit(CW_MDRIN);
            in_wait = 1'b1;
            if (!MemReady) state_d = ST_T6;
          end
          CLS_ST: cw = cw_bit(CW_GRA) | cw_bit(CW_ROUT) | cw_bit(CW_MDRIN);
          CLS_BR: begin
            cw        = cw_bit(CW_ZLOOUT) | cw_bit(CW_PCIN);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T7: begin
        case (cls_cur)
          CLS_LD: begin
            cw        = cw_bit(CW_MDROUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN);
            last_step = 1'b1;
          end
          CLS_ST: begin
            cw        = cw_bit(CW_WRITE);
            in_wait   = 1'b1;
            last_step = MemReady;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_HALT: begin
        if (Resume && !Stop) state_d = ST_F0;
      end
      // Unreachable encodings park safely with Run low.
      default: state_d = ST_HALT;
    endcase

    // A MemReady arriving on the timeout cycle still completes normally.
    if (WAIT_MAX != 0 && in_wait && !MemReady && wait_cnt_q == CNT_W'(WAIT_LAST)) begin
      set_bus_err = 1'b1;
      state_d     = ST_HALT;
    end

    if (last_step) state_d = Stop ? ST_HALT : ST_F0;

    // Counter restarts on every entry into a wait step.
    wait_cnt_d = (in_wait && state_d == state_q) ? wait_cnt_q + CNT_W'(1) : '0;
  end

  // NOTE: the class register is reset too even though T3 always overwrites
  // it before use, so no state is ever X after Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_INIT;
      cls_q      <= CLS_NOP;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
      ill_op_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == ST_T3) cls_q <= dec_cls;
      if (set_bus_err)      bus_err_q <= 1'b1;
      if (set_ill)          ill_op_q  <= 1'b1;
    end
  end

  assign CW     = cw;
  assign RegClr = reg_clr;
  assign Run    = (state_q != ST_HALT);
  assign BusErr = bus_err_q;
  assign IllOp  = ill_op_q;
  assign State  = state_q;

endmodule
